// File: rtl/uc_pkg.sv
// Shared types and constants for the uc_seq microcontroller sequencer.
package uc_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_RUN    = 3'd1,
        S_WAIT   = 3'd2,
        S_HALT   = 3'd3,
        S_RESUME = 3'd4
    } state_t;

    // Control-flow opcodes (the 00xxxx group)
    localparam logic [5:0] OPC_J    = 6'b000000;
    localparam logic [5:0] OPC_JZ   = 6'b000001;
    localparam logic [5:0] OPC_JNZ  = 6'b000010;
    localparam logic [5:0] OPC_HALT = 6'b000011;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    // Raw decoder output, before commit gating
    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
        logic       is_halt;
    } dec_t;

endpackage

// File: rtl/uc_decode.sv
// Purely combinational opcode decoder. i_halt_nop makes the halt opcode
// decode as a plain nop (used for the single re-entry cycle after HALT).
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic       i_z,
    input  logic       i_halt_nop,
    output dec_t       o_dec
);

    // Decode table; everything not explicitly set stays 0
    always_comb begin
        o_dec = '0;
        if (i_opcode[5]) begin
            o_dec.op    = i_opcode[4:2];
            o_dec.we3   = 1'b1;
            o_dec.wez   = 1'b1;
            o_dec.s_inc = 1'b1;
        end else if (i_opcode[4]) begin
            o_dec.s_inm = 1'b1;
            o_dec.we3   = 1'b1;
            o_dec.s_inc = 1'b1;
        end else begin
            case (i_opcode)
                OPC_J:    o_dec.s_inc = 1'b0;
                OPC_JZ:   o_dec.s_inc = ~i_z;
                OPC_JNZ:  o_dec.s_inc = i_z;
                OPC_HALT: begin
                    o_dec.is_halt = ~i_halt_nop;
                    o_dec.s_inc   = i_halt_nop;
                end
                default:  o_dec.s_inc = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc_seq.sv
// Run/step/halt sequencer wrapped around the microc decoder.
// Optional committed-instruction counter enabled by defining UC_ICOUNT_EN;
// otherwise icount is tied to 0 and no counter flops are built.
module uc_seq
    import uc_pkg::*;
#(
    parameter int ICNT_W = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        Opcode,
    input  logic              z,
    input  logic              run_mode,
    input  logic              step,
    input  logic              resume,
    output logic              s_inc,
    output logic              s_inm,
    output logic              we3,
    output logic              wez,
    output logic [2:0]        Op,
    output logic              pc_we,
    output logic              halted,
    output logic              busy,
    output logic [ICNT_W-1:0] icount
);

    state_t r_state;
    state_t w_next;
    logic   r_step_q;
    logic   w_step_edge;
    logic   w_commit;
    logic   w_halt_nop;
    dec_t   w_dec;

    assign w_step_edge = step & ~r_step_q;

    uc_decode u_decode (
        .i_opcode   (Opcode),
        .i_z        (z),
        .i_halt_nop (w_halt_nop),
        .o_dec      (w_dec)
    );

    // State register and step edge detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_INIT;
            r_step_q <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_step_q <= step;
        end
    end

    // Next-state logic; halt outranks a run_mode drop, run_mode outranks a step
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = run_mode ? S_RUN : S_WAIT;
            S_RUN: begin
                if (w_dec.is_halt)  w_next = S_HALT;
                else if (!run_mode) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (run_mode)                         w_next = S_RUN;
                else if (w_step_edge && w_dec.is_halt) w_next = S_HALT;
            end
            S_HALT:   if (resume) w_next = S_RESUME;
            S_RESUME: w_next = run_mode ? S_RUN : S_WAIT;
            default:  w_next = S_INIT;
        endcase
    end

    // Commit decision per state; RESUME re-executes halt as a nop
    always_comb begin
        w_commit   = 1'b0;
        w_halt_nop = (r_state == S_RESUME);
        case (r_state)
            S_RUN:    w_commit = ~w_dec.is_halt;
            S_WAIT:   w_commit = ~run_mode & w_step_edge & ~w_dec.is_halt;
            S_RESUME: w_commit = 1'b1;
            default:  w_commit = 1'b0;
        endcase
    end

    // Outputs are gated by reset level so a mid-cycle reset kills them at once
    always_comb begin
        pc_we  = w_commit & reset;
        s_inc  = w_dec.s_inc & reset;
        s_inm  = w_dec.s_inm & reset;
        we3    = w_dec.we3 & w_commit & reset;
        wez    = w_dec.wez & w_commit & reset;
        Op     = w_dec.op & {3{reset}};
        halted = (r_state == S_HALT) & reset;
        busy   = (r_state == S_RUN) & reset;
    end

`ifdef UC_ICOUNT_EN
    localparam logic [ICNT_W-1:0] ICNT_ONE = ICNT_W'(1);
    logic [ICNT_W-1:0] r_icount;

    // Saturating commit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_icount <= '0;
        else if (w_commit && !(&r_icount))
            r_icount <= r_icount + ICNT_ONE;
    end

    assign icount = r_icount;
`else
    assign icount = '0;
`endif

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed scenarios plus a randomized run,
// all compared against a behavioural model of the run/step/halt rules.
module tb_uc_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [5:0]   Opcode = 6'd0;
    logic         z = 1'b0;
    logic         run_mode = 1'b0;
    logic         step = 1'b0;
    logic         resume = 1'b0;
    logic         s_inc, s_inm, we3, wez, pc_we, halted, busy;
    logic [2:0]   Op;
    logic [W-1:0] icount;

    int checks = 0;
    int errors = 0;

    uc_seq #(.ICNT_W(W)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run_mode(run_mode),
        .step(step), .resume(resume), .s_inc(s_inc), .s_inm(s_inm), .we3(we3),
        .wez(wez), .Op(Op), .pc_we(pc_we), .halted(halted), .busy(busy),
        .icount(icount)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum int {M_BOOT, M_FREE, M_STEPPED, M_STOPPED, M_RESTART} mph_t;
    mph_t m_ph = M_BOOT;
    bit   m_stepq = 1'b0;
    int   m_cnt = 0;

    function automatic bit m_commit();
        bit is_halt = (Opcode == 6'd3);
        bit redge   = step && !m_stepq;
        case (m_ph)
            M_FREE:    return !is_halt;
            M_STEPPED: return !run_mode && redge && !is_halt;
            M_RESTART: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

    // {s_inc, s_inm, we3, wez, Op, pc_we, halted, busy}
    function automatic logic [9:0] m_vec();
        bit si = 0, sm = 0, w = 0, wz = 0, c;
        logic [2:0] op = 3'd0;
        int oc = int'(Opcode);
        c = m_commit();
        if (!reset) return 10'd0;
        if (oc >= 32) begin op = Opcode[4:2]; w = 1; wz = 1; si = 1; end
        else if (oc >= 16) begin sm = 1; w = 1; si = 1; end
        else if (oc == 0) si = 0;
        else if (oc == 1) si = !z;
        else if (oc == 2) si = z;
        else if (oc == 3) si = (m_ph == M_RESTART);
        else si = 1;
        return {si, sm, w & c, wz & c, op, c, m_ph == M_STOPPED, m_ph == M_FREE};
    endfunction

    function automatic logic [W-1:0] m_icnt();
`ifdef UC_ICOUNT_EN
        int mx = (1 << W) - 1;
        int v  = (m_cnt > mx) ? mx : m_cnt;
        return v[W-1:0];
`else
        return '0;
`endif
    endfunction

    function automatic logic [9:0] d_vec();
        return {s_inc, s_inm, we3, wez, Op, pc_we, halted, busy};
    endfunction

    task automatic model_reset();
        m_ph = M_BOOT; m_stepq = 0; m_cnt = 0;
    endtask

    // Advance one clock; model follows the same sampled inputs
    task automatic tick();
        bit c, is_halt, redge;
        @(posedge clk);
        if (reset) begin
            c = m_commit();
            is_halt = (Opcode == 6'd3);
            redge = step && !m_stepq;
            case (m_ph)
                M_BOOT:    m_ph = run_mode ? M_FREE : M_STEPPED;
                M_FREE:    if (is_halt) m_ph = M_STOPPED;
                           else if (!run_mode) m_ph = M_STEPPED;
                M_STEPPED: if (run_mode) m_ph = M_FREE;
                           else if (redge && is_halt) m_ph = M_STOPPED;
                M_STOPPED: if (resume) m_ph = M_RESTART;
                M_RESTART: m_ph = run_mode ? M_FREE : M_STEPPED;
                default:   m_ph = M_BOOT;
            endcase
            m_cnt += int'(c);
            m_stepq = step;
        end
        @(negedge clk);
    endtask

    // Reset then release into RUN with an ALU opcode present
    task automatic boot_run();
        reset = 0; model_reset();
        run_mode = 1; step = 0; resume = 0; z = 0; Opcode = 6'b101000;
        @(negedge clk);
        reset = 1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 0; model_reset();
        for (int i = 0; i < 3; i++) begin
            Opcode = 6'($urandom); z = 1'($urandom); run_mode = 1'($urandom);
            step = 1'($urandom); resume = 1'($urandom);
            #1;
            checks++;
            if (d_vec() !== 10'd0) begin
                errors++; $display("FAIL reset_ctl got %b want 0", d_vec());
            end
            checks++;
            if (icount !== '0) begin
                errors++; $display("FAIL reset_icount got %0d want 0", icount);
            end
            tick();
        end
    endtask

    task automatic test_boot();
        run_mode = 1; step = 0; resume = 0; z = 0; Opcode = 6'b101000;
        reset = 1;
        #1;
        checks++;
        if (pc_we !== 1'b0 || d_vec() !== m_vec()) begin
            errors++; $display("FAIL boot_c1 got %b want %b", d_vec(), m_vec());
        end
        tick();
        #1;
        checks++;
        if ({pc_we, we3, wez, Op, busy} !== {3'b111, 3'b010, 1'b1}) begin
            errors++; $display("FAIL boot_c2 got %b want 1110101", {pc_we, we3, wez, Op, busy});
        end
        tick();
    endtask

    task automatic test_jnz();
        Opcode = 6'b000010; z = 0; #1;
        checks++;
        if ({s_inc, pc_we} !== 2'b01 || d_vec() !== m_vec()) begin
            errors++; $display("FAIL jnz_z0 got %b want %b", d_vec(), m_vec());
        end
        tick();
        z = 1; #1;
        checks++;
        if ({s_inc, pc_we} !== 2'b11 || d_vec() !== m_vec()) begin
            errors++; $display("FAIL jnz_z1 got %b want %b", d_vec(), m_vec());
        end
        tick();
        Opcode = 6'b001000; #1;
        checks++;
        if (icount !== m_icnt()) begin
            errors++; $display("FAIL jnz_icount got %0d want %0d", icount, m_icnt());
        end
    endtask

    task automatic test_halt_resume();
        Opcode = 6'b000011; run_mode = 1; #1;
        checks++;
        if (pc_we !== 1'b0 || d_vec() !== m_vec()) begin
            errors++; $display("FAIL halt_c0 got %b want %b", d_vec(), m_vec());
        end
        tick();
        step = 1; #1;
        checks++;
        if ({halted, pc_we} !== 2'b10 || d_vec() !== m_vec()) begin
            errors++; $display("FAIL halt_c1 got %b want %b", d_vec(), m_vec());
        end
        tick();
        step = 0; resume = 1; #1;
        checks++;
        if (pc_we !== 1'b0 || d_vec() !== m_vec()) begin
            errors++; $display("FAIL halt_resume got %b want %b", d_vec(), m_vec());
        end
        tick();
        resume = 0; #1;
        checks++;
        if ({pc_we, s_inc, halted} !== 3'b110 || d_vec() !== m_vec()) begin
            errors++; $display("FAIL resume_commit got %b want %b", d_vec(), m_vec());
        end
        tick();
        Opcode = 6'b001000; #1;
        checks++;
        if (busy !== 1'b1 || d_vec() !== m_vec()) begin
            errors++; $display("FAIL resume_run got %b want %b", d_vec(), m_vec());
        end
        tick();
    endtask

    task automatic test_step_hold();
        int commits = 0;
        logic [W-1:0] exp_cnt;
        Opcode = 6'b110100; run_mode = 0; step = 0;
        tick();
        step = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            commits += int'(pc_we);
            checks++;
            if (d_vec() !== m_vec()) begin
                errors++; $display("FAIL step_cyc%0d got %b want %b", i, d_vec(), m_vec());
            end
            tick();
        end
        exp_cnt = m_icnt();
        checks++;
        if (commits !== 1) begin
            errors++; $display("FAIL step_commits got %0d want 1", commits);
        end
        checks++;
        if (icount !== exp_cnt) begin
            errors++; $display("FAIL step_icount got %0d want %0d", icount, exp_cnt);
        end
        step = 0;
    endtask

    task automatic test_async_reset();
        boot_run();
        Opcode = 6'b101100;
        tick();
        #2;
        reset = 0; model_reset();
        #1;
        checks++;
        if ({we3, wez, pc_we} !== 3'b000) begin
            errors++; $display("FAIL async_rst got %b want 000", {we3, wez, pc_we});
        end
        checks++;
        if (icount !== '0) begin
            errors++; $display("FAIL async_rst_icount got %0d want 0", icount);
        end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        logic [W-1:0] exp_sat;
`ifdef UC_ICOUNT_EN
        exp_sat = '1;
`else
        exp_sat = '0;
`endif
        boot_run();
        for (int i = 0; i < 20; i++) tick();
        #1;
        checks++;
        if (icount !== exp_sat || icount !== m_icnt()) begin
            errors++; $display("FAIL saturate got %0d want %0d", icount, exp_sat);
        end
    endtask

    task automatic test_random();
        boot_run();
        for (int i = 0; i < 400; i++) begin
            Opcode = ($urandom_range(0, 7) == 0) ? 6'd3 : 6'($urandom);
            z = 1'($urandom);
            step = 1'($urandom);
            resume = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) run_mode = ~run_mode;
            if ($urandom_range(0, 63) == 0) begin
                reset = 0; model_reset();
            end else begin
                reset = 1;
            end
            #1;
            checks++;
            if (d_vec() !== m_vec()) begin
                errors++; $display("FAIL rand_ctl cyc%0d got %b want %b", i, d_vec(), m_vec());
            end
            checks++;
            if (icount !== m_icnt()) begin
                errors++; $display("FAIL rand_icount cyc%0d got %0d want %0d", i, icount, m_icnt());
            end
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_boot();
        test_jnz();
        test_halt_resume();
        test_step_hold();
        test_async_reset();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
